// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW processing element: back-pointer encodings,
// distance-mode encodings and the local-cost width helper.
package dtw_pkg;

  typedef enum logic [1:0] {
    PATH_ORIG = 2'b00,
    PATH_LEFT = 2'b01,
    PATH_UP   = 2'b10,
    PATH_DIAG = 2'b11
  } path_e;

  localparam logic MODE_L1 = 1'b0;
  localparam logic MODE_L2 = 1'b1;

  // Width of the channel sum: one squared (FW+1)-bit difference plus
  // headroom for adding NCH of them without wrap.
  function automatic int lw_f(input int nch, input int fw);
    return 2 * fw + 1 + $clog2(nch);
  endfunction

endpackage

// File: rtl/dtw_local_cost.sv
// Combinational local cost between a test and a reference vector:
// sum of |r-t| (L1) or (r-t)^2 (squared L2) over NCH signed channels.
module dtw_local_cost
  import dtw_pkg::*;
#(
  parameter  int NCH = 3,
  parameter  int FW  = 10,
  localparam int LW  = lw_f(NCH, FW)
) (
  input  logic [NCH*FW-1:0] t_vec,
  input  logic [NCH*FW-1:0] r_vec,
  input  logic              mode,
  output logic [LW-1:0]     cost
);

  always_comb begin
    logic        [FW-1:0] w_t_ch;
    logic        [FW-1:0] w_r_ch;
    logic signed [FW:0]   w_diff;
    logic        [FW:0]   w_abs;
    logic signed [2*FW:0] w_sq;
    logic        [2*FW:0] w_term;
    // NOTE: every variable written here gets a value on every pass before it
    // is read, so the block stays purely combinational (no latch inferred).
    cost   = '0;
    w_t_ch = '0;
    w_r_ch = '0;
    w_diff = '0;
    w_abs  = '0;
    w_sq   = '0;
    w_term = '0;
    for (int c = 0; c < NCH; c++) begin
      w_t_ch = t_vec[(NCH-1-c)*FW +: FW];
      w_r_ch = r_vec[(NCH-1-c)*FW +: FW];
      // One extra bit so -2^(FW-1) vs 2^(FW-1)-1 cannot wrap.
      w_diff = $signed({w_r_ch[FW-1], w_r_ch}) - $signed({w_t_ch[FW-1], w_t_ch});
      w_abs  = w_diff[FW] ? $unsigned(-w_diff) : $unsigned(w_diff);
      w_sq   = (2*FW+1)'(w_diff) * (2*FW+1)'(w_diff);
      w_term = (mode == MODE_L2) ? $unsigned(w_sq) : (2*FW+1)'(w_abs);
      cost   = cost + LW'(w_term);
    end
  end

endmodule

// File: rtl/dtw_pe_pipe.sv
// Two-stage pipelined DTW processing element: local cost plus the minimum
// predecessor cost, with saturation, back-pointer and valid/ready flow control.
module dtw_pe_pipe
  import dtw_pkg::*;
#(
  parameter int NCH = 3,
  parameter int FW  = 10,
  parameter int DW  = 16,
  parameter int IW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic              first_row,
  input  logic              first_col,
  input  logic [NCH*FW-1:0] t_vec,
  input  logic [NCH*FW-1:0] r_vec,
  input  logic [IW-1:0]     t_idx,
  input  logic [IW-1:0]     r_idx,
  input  logic [DW-1:0]     d_diag,
  input  logic [DW-1:0]     d_up,
  input  logic [DW-1:0]     d_left,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     d_out,
  output logic [1:0]        path_out,
  output logic [IW-1:0]     t_idx_out,
  output logic [IW-1:0]     r_idx_out,
  output logic              sat
);

  localparam int LW = lw_f(NCH, FW);
  localparam int SW = ((DW > LW) ? DW : LW) + 1;

  logic [LW-1:0] w_cost;
  logic [DW-1:0] w_min;
  path_e         w_path;
  logic          w_s1_adv;
  logic          w_s2_adv;
  logic [SW-1:0] w_sum;
  logic          w_over;

  logic          r_s1_v;
  logic [LW-1:0] r_s1_cost;
  logic [DW-1:0] r_s1_min;
  path_e         r_s1_path;
  logic [IW-1:0] r_s1_t_idx;
  logic [IW-1:0] r_s1_r_idx;

  logic          r_out_v;
  logic [DW-1:0] r_d_out;
  path_e         r_path;
  logic [IW-1:0] r_t_idx;
  logic [IW-1:0] r_r_idx;
  logic          r_sat;

  dtw_local_cost #(
    .NCH (NCH),
    .FW  (FW)
  ) u_local_cost (
    .t_vec (t_vec),
    .r_vec (r_vec),
    .mode  (mode),
    .cost  (w_cost)
  );

  // Ties resolve diag > up > left; edge cells only see the predecessors they have.
  always_comb begin
    w_min  = '0;
    w_path = PATH_ORIG;
    if (first_row && first_col) begin
      w_min  = '0;
      w_path = PATH_ORIG;
    end else if (first_row) begin
      w_min  = d_left;
      w_path = PATH_LEFT;
    end else if (first_col) begin
      w_min  = d_up;
      w_path = PATH_UP;
    end else if ((d_diag <= d_up) && (d_diag <= d_left)) begin
      w_min  = d_diag;
      w_path = PATH_DIAG;
    end else if (d_up <= d_left) begin
      w_min  = d_up;
      w_path = PATH_UP;
    end else begin
      w_min  = d_left;
      w_path = PATH_LEFT;
    end
  end

  assign w_s2_adv = ~r_out_v | out_ready;
  assign w_s1_adv = ~r_s1_v | w_s2_adv;
  assign in_ready = w_s1_adv;

  assign w_sum  = SW'(r_s1_min) + SW'(r_s1_cost);
  assign w_over = |w_sum[SW-1:DW];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values no matter how the statements are ordered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v     <= 1'b0;
      r_s1_cost  <= '0;
      r_s1_min   <= '0;
      r_s1_path  <= PATH_ORIG;
      r_s1_t_idx <= '0;
      r_s1_r_idx <= '0;
    end else if (flush) begin
      r_s1_v <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_v <= in_valid;
      // NOTE: payload regs load only with a beat; the valid bit qualifies them,
      // so they need no clearing on flush.
      if (in_valid) begin
        r_s1_cost  <= w_cost;
        r_s1_min   <= w_min;
        r_s1_path  <= w_path;
        r_s1_t_idx <= t_idx;
        r_s1_r_idx <= r_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_v <= 1'b0;
      r_d_out <= '0;
      r_path  <= PATH_ORIG;
      r_t_idx <= '0;
      r_r_idx <= '0;
      r_sat   <= 1'b0;
    end else if (flush) begin
      r_out_v <= 1'b0;
      r_d_out <= '0;
      r_path  <= PATH_ORIG;
      r_t_idx <= '0;
      r_r_idx <= '0;
      r_sat   <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_v <= r_s1_v;
      if (r_s1_v) begin
        r_d_out <= w_over ? '1 : w_sum[DW-1:0];
        r_sat   <= w_over;
        r_path  <= r_s1_path;
        r_t_idx <= r_s1_t_idx;
        r_r_idx <= r_s1_r_idx;
      end
    end
  end

  assign out_valid = r_out_v;
  assign d_out     = r_d_out;
  assign path_out  = r_path;
  assign t_idx_out = r_t_idx;
  assign r_idx_out = r_r_idx;
  assign sat       = r_sat;

endmodule

// File: tb/tb_dtw_pe_pipe.sv
// Self-checking bench for dtw_pe_pipe: directed cost/tie/edge/saturation cases,
// backpressure, flush and reset, then a randomised stream against a model.
module tb_dtw_pe_pipe;

  localparam logic L1 = 1'b0;
  localparam logic L2 = 1'b1;

  typedef struct packed {
    logic        sat;
    logic [1:0]  path;
    logic [4:0]  ti;
    logic [4:0]  ri;
    logic [15:0] d;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic        first_row;
  logic        first_col;
  logic [29:0] t_vec;
  logic [29:0] r_vec;
  logic [4:0]  t_idx;
  logic [4:0]  r_idx;
  logic [15:0] d_diag;
  logic [15:0] d_up;
  logic [15:0] d_left;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d_out;
  logic [1:0]  path_out;
  logic [4:0]  t_idx_out;
  logic [4:0]  r_idx_out;
  logic        sat;

  int n_cmp = 0;
  int n_err = 0;
  int tag_n = 0;

  dtw_pe_pipe #(
    .NCH (3),
    .FW  (10),
    .DW  (16),
    .IW  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .first_row (first_row),
    .first_col (first_col),
    .t_vec     (t_vec),
    .r_vec     (r_vec),
    .t_idx     (t_idx),
    .r_idx     (r_idx),
    .d_diag    (d_diag),
    .d_up      (d_up),
    .d_left    (d_left),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d_out     (d_out),
    .path_out  (path_out),
    .t_idx_out (t_idx_out),
    .r_idx_out (r_idx_out),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [29:0] pack3(input int a, input int b, input int c);
    return {10'(a), 10'(b), 10'(c)};
  endfunction

  // Behavioural reference: integer arithmetic, no width tricks.
  function automatic res_t model(input logic m, input logic fr, input logic fc,
                                 input logic [29:0] tv, input logic [29:0] rv,
                                 input logic [15:0] dg, input logic [15:0] du,
                                 input logic [15:0] dl, input logic [4:0] ti,
                                 input logic [4:0] ri);
    res_t               r;
    int                 cost = 0;
    int                 mn;
    int                 s;
    int                 d;
    logic [1:0]         p;
    logic signed [9:0]  ts;
    logic signed [9:0]  rs;
    for (int c = 0; c < 3; c++) begin
      ts = tv[29-10*c -: 10];
      rs = rv[29-10*c -: 10];
      d  = int'(rs) - int'(ts);
      cost += m ? d * d : ((d < 0) ? -d : d);
    end
    if (fr && fc)                    begin mn = 0;      p = 2'b00; end
    else if (fr)                     begin mn = int'(dl); p = 2'b01; end
    else if (fc)                     begin mn = int'(du); p = 2'b10; end
    else if (dg <= du && dg <= dl)   begin mn = int'(dg); p = 2'b11; end
    else if (du <= dl)               begin mn = int'(du); p = 2'b10; end
    else                             begin mn = int'(dl); p = 2'b01; end
    s      = mn + cost;
    r.sat  = (s > 65535);
    r.d    = r.sat ? 16'hFFFF : 16'(s);
    r.path = p;
    r.ti   = ti;
    r.ri   = ri;
    return r;
  endfunction

  function automatic res_t observed();
    return {sat, path_out, t_idx_out, r_idx_out, d_out};
  endfunction

  task automatic drive(input logic m, input logic fr, input logic fc,
                       input logic [29:0] tv, input logic [29:0] rv,
                       input logic [15:0] dg, input logic [15:0] du, input logic [15:0] dl,
                       input logic [4:0] ti, input logic [4:0] ri);
    mode      = m;
    first_row = fr;
    first_col = fc;
    t_vec     = tv;
    r_vec     = rv;
    d_diag    = dg;
    d_up      = du;
    d_left    = dl;
    t_idx     = ti;
    r_idx     = ri;
    in_valid  = 1'b1;
  endtask

  // One beat into an empty pipe with out_ready high; result expected exactly 2 edges later.
  task automatic run_single(input string tag, input logic m, input logic fr, input logic fc,
                            input logic [29:0] tv, input logic [29:0] rv,
                            input logic [15:0] dg, input logic [15:0] du, input logic [15:0] dl,
                            input logic [15:0] ed, input logic [1:0] ep, input logic es);
    logic [4:0] ti;
    logic [4:0] ri;
    tag_n++;
    ti = 5'(tag_n);
    ri = ~ti;
    @(negedge clk);
    out_ready = 1'b1;
    drive(m, fr, fc, tv, rv, dg, du, dl, ti, ri);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_d"}, 32'(d_out), 32'(ed));
    check({tag, "_path"}, 32'(path_out), 32'(ep));
    check({tag, "_sat"}, 32'(sat), 32'(es));
    check({tag, "_tags"}, {22'd0, t_idx_out, r_idx_out}, {22'd0, ti, ri});
  endtask

  task automatic expect_bp(input string tag, input int k);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_d"}, 32'(d_out), 32'(10 * k));
    check({tag, "_tags"}, {22'd0, t_idx_out, r_idx_out}, {22'd0, 5'(k), 5'(20 + k)});
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_state"}, 32'(observed()), 32'd0);
  endtask

  function automatic int rand_ch();
    case ($urandom_range(7))
      0:       return -512;
      1:       return 511;
      default: return int'($urandom_range(1023)) - 512;
    endcase
  endfunction

  function automatic logic [15:0] rand_d();
    case ($urandom_range(3))
      0:       return 16'(65400 + $urandom_range(135));
      1:       return 16'($urandom_range(3));
      default: return 16'($urandom_range(65535));
    endcase
  endfunction

  task automatic random_run(input int nbeats);
    res_t q[$];
    res_t e;
    res_t held;
    logic hold_pending = 1'b0;
    logic busy = 1'b0;
    int   sent = 0;
    int   got = 0;
    int   cyc = 0;
    int   budget;
    budget = 3 * nbeats + 100;
    while (got < nbeats && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (hold_pending)
        check("rand_hold", 32'(observed()), 32'(held));
      out_ready = ($urandom_range(3) != 0);
      if (!busy) begin
        if (sent < nbeats && $urandom_range(3) != 0) begin
          drive(1'($urandom_range(1)), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                pack3(rand_ch(), rand_ch(), rand_ch()), pack3(rand_ch(), rand_ch(), rand_ch()),
                rand_d(), rand_d(), rand_d(), 5'($urandom_range(31)), 5'($urandom_range(31)));
          busy = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("rand_res", 32'(observed()), 32'(e));
          got++;
        end
      end
      hold_pending = out_valid && !out_ready;
      held = observed();
      if (in_valid && in_ready) begin
        q.push_back(model(mode, first_row, first_col, t_vec, r_vec,
                          d_diag, d_up, d_left, t_idx, r_idx));
        sent++;
        busy = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("rand_count", 32'(got), 32'(nbeats));
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mode      = L1;
    first_row = 1'b0;
    first_col = 1'b0;
    t_vec     = '0;
    r_vec     = '0;
    t_idx     = '0;
    r_idx     = '0;
    d_diag    = '0;
    d_up      = '0;
    d_left    = '0;

    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // Basic cost and minimum selection.
    run_single("l1_basic", L1, 1'b0, 1'b0, pack3(5, -3, 100), pack3(2, 4, 100),
               16'd20, 16'd15, 16'd30, 16'd25, 2'b10, 1'b0);
    run_single("tie_all", L1, 1'b0, 1'b0, pack3(1, 2, 3), pack3(1, 2, 3),
               16'd7, 16'd7, 16'd7, 16'd7, 2'b11, 1'b0);
    run_single("tie_up_left", L1, 1'b0, 1'b0, pack3(1, 2, 3), pack3(1, 2, 3),
               16'd8, 16'd7, 16'd7, 16'd7, 2'b10, 1'b0);
    run_single("left_min", L1, 1'b0, 1'b0, pack3(1, 2, 3), pack3(1, 2, 3),
               16'd9, 16'd8, 16'd7, 16'd7, 2'b01, 1'b0);

    // Edge cells.
    run_single("l2_origin", L2, 1'b1, 1'b1, pack3(3, 0, 0), pack3(0, 4, 0),
               16'd1, 16'd1, 16'd1, 16'd25, 2'b00, 1'b0);
    run_single("l2_first_row", L2, 1'b1, 1'b0, pack3(3, 0, 0), pack3(0, 4, 0),
               16'd0, 16'd0, 16'd9, 16'd34, 2'b01, 1'b0);
    run_single("l2_first_col", L2, 1'b0, 1'b1, pack3(3, 0, 0), pack3(0, 4, 0),
               16'd0, 16'd50, 16'd0, 16'd75, 2'b10, 1'b0);

    // Saturation boundary and channel extremes.
    run_single("sat_l1", L1, 1'b0, 1'b0, pack3(5, -3, 100), pack3(2, 4, 100),
               16'd65530, 16'd65530, 16'd65530, 16'd65535, 2'b11, 1'b1);
    run_single("nosat_max", L1, 1'b0, 1'b0, pack3(0, 0, 0), pack3(5, 0, 0),
               16'd65530, 16'd65530, 16'd65530, 16'd65535, 2'b11, 1'b0);
    run_single("ext_l2", L2, 1'b1, 1'b1, pack3(-512, -512, -512), pack3(511, 511, 511),
               16'd0, 16'd0, 16'd0, 16'd65535, 2'b00, 1'b1);
    run_single("ext_l1", L1, 1'b1, 1'b1, pack3(-512, -512, -512), pack3(511, 511, 511),
               16'd0, 16'd0, 16'd0, 16'd3069, 2'b00, 1'b0);
    run_single("ext_l1_rev", L1, 1'b1, 1'b1, pack3(511, 511, 511), pack3(-512, -512, -512),
               16'd0, 16'd0, 16'd0, 16'd3069, 2'b00, 1'b0);
    run_single("l2_wide", L2, 1'b1, 1'b1, pack3(-75, -50, -85), pack3(75, 50, 85),
               16'd0, 16'd0, 16'd0, 16'd61400, 2'b00, 1'b0);
    run_single("l2_edge_nosat", L2, 1'b1, 1'b0, pack3(-75, -50, -85), pack3(75, 50, 85),
               16'd0, 16'd0, 16'd4135, 16'd65535, 2'b01, 1'b0);
    run_single("l2_edge_sat", L2, 1'b1, 1'b0, pack3(-75, -50, -85), pack3(75, 50, 85),
               16'd0, 16'd0, 16'd4136, 16'd65535, 2'b01, 1'b1);

    // Backpressure: 4 beats, output held for 3 cycles.
    @(negedge clk);
    out_ready = 1'b0;
    drive(L1, 1'b1, 1'b1, pack3(0, 0, 0), pack3(10, 0, 0), 16'd0, 16'd0, 16'd0, 5'd1, 5'd21);
    #1 check("bp_rdy_a", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(L1, 1'b1, 1'b1, pack3(0, 0, 0), pack3(20, 0, 0), 16'd0, 16'd0, 16'd0, 5'd2, 5'd22);
    #1 check("bp_rdy_b", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(L1, 1'b1, 1'b1, pack3(0, 0, 0), pack3(30, 0, 0), 16'd0, 16'd0, 16'd0, 5'd3, 5'd23);
    #1 check("bp_rdy_full", 32'(in_ready), 32'd0);
    expect_bp("bp_hold0", 1);
    for (int h = 1; h < 3; h++) begin
      @(negedge clk);
      #1 check("bp_rdy_held", 32'(in_ready), 32'd0);
      expect_bp("bp_hold", 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("bp_rdy_rel", 32'(in_ready), 32'd1);
    expect_bp("bp_out1", 1);
    @(negedge clk);
    drive(L1, 1'b1, 1'b1, pack3(0, 0, 0), pack3(40, 0, 0), 16'd0, 16'd0, 16'd0, 5'd4, 5'd24);
    #1 expect_bp("bp_out2", 2);
    @(negedge clk);
    in_valid = 1'b0;
    #1 expect_bp("bp_out3", 3);
    @(negedge clk);
    #1 expect_bp("bp_out4", 4);
    @(negedge clk);
    #1 check("bp_drained", 32'(out_valid), 32'd0);

    // Flush with one result presented, one in S1 and a new beat offered.
    @(negedge clk);
    drive(L1, 1'b0, 1'b0, pack3(0, 0, 0), pack3(100, 0, 0), 16'd0, 16'd0, 16'd0, 5'd7, 5'd8);
    @(negedge clk);
    drive(L1, 1'b0, 1'b0, pack3(0, 0, 0), pack3(200, 0, 0), 16'd0, 16'd0, 16'd0, 5'd9, 5'd10);
    @(negedge clk);
    check("fl_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    drive(L1, 1'b0, 1'b0, pack3(0, 0, 0), pack3(50, 0, 0), 16'd0, 16'd0, 16'd0, 5'd11, 5'd12);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check_cleared("fl_clear");
    repeat (2) begin
      @(negedge clk);
      check("fl_no_stale", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset with two beats in flight.
    @(negedge clk);
    drive(L1, 1'b0, 1'b0, pack3(0, 0, 0), pack3(100, 0, 0), 16'd0, 16'd0, 16'd0, 5'd13, 5'd14);
    @(negedge clk);
    drive(L1, 1'b0, 1'b0, pack3(0, 0, 0), pack3(200, 0, 0), 16'd0, 16'd0, 16'd0, 5'd15, 5'd16);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1 check_cleared("rst_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end

    random_run(10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
